// File: rtl/loader_pkg.sv
// Shared types and constants for the UART boot loader.
package loader_pkg;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  localparam logic [7:0] LOADER_MAGIC = 8'hA5;

  // Byte counts of the little-endian frame fields
  localparam int unsigned ADDR_BYTES = 4;
  localparam int unsigned LEN_BYTES  = 4;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [2:0] {
    S_MAGIC,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_SETUP,
    S_ACCESS,
    S_DONE
  } loader_state_e;

  typedef struct packed {
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pwrite;
    logic [SW-1:0] pwstrb;
  } apb_req_t;

endpackage

// File: rtl/uart_loader_rx.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling, one-cycle byte strobe.
module uart_loader_rx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_vld,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;

  rx_state_e         state_q, state_d;
  logic [1:0]        sync_q;
  logic              prev_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        data_q, data_d;
  logic              vld_q, vld_d;
  logic              ferr_q, ferr_d;
  logic              rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= R_IDLE;
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], rx};
      prev_q  <= rx_s;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
    end
  end

  // Start bit is re-checked at half a bit; every later sample lands mid-bit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    vld_d   = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      R_IDLE: begin
        cnt_d = '0;
        if (prev_q && !rx_s) state_d = R_START;
      end
      R_START: begin
        if (cnt_q == CNT_W'(HALF - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = R_STOP;
        end
      end
      R_STOP: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          state_d = R_IDLE;
          if (rx_s) begin
            vld_d  = 1'b1;
            data_d = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  assign byte_vld  = vld_q;
  assign byte_data = data_q;
  assign frame_err = ferr_q;

endmodule

// File: rtl/uart_loader.sv
// UART boot loader: parses a framed image and writes it to RAM as an APB master,
// holding the core in reset until the image is complete.
module uart_loader
  import loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  MAGIC        = LOADER_MAGIC,
  parameter logic [31:0] ADDR_MASK    = 32'hFFFF_FFFC
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx,
  output logic          psel,
  output logic          penable,
  input  logic          pready,
  output logic [AW-1:0] paddr,
  output logic          pwrite,
  output logic [DW-1:0] pwdata,
  output logic [SW-1:0] pwstrb,
  input  logic [DW-1:0] prdata,
  input  logic          pslverr,
  output logic          core_rst_n,
  output logic          busy,
  output logic          err
);

  localparam int unsigned IDX_W = 2;

  logic       byte_vld;
  logic [7:0] byte_data;
  logic       frame_err;

  uart_loader_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .byte_vld (byte_vld),
    .byte_data(byte_data),
    .frame_err(frame_err)
  );

  loader_state_e   state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [23:0]     shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic            hold_vld_q, hold_vld_d;
  logic [7:0]      hold_q, hold_d;
  logic            err_q, err_d;
  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  apb_req_t        req_q, req_d;
  logic            core_rst_n_q, core_rst_n_d;
  logic            busy_q, busy_d;
  logic            consume;
  logic [31:0]     word;

  logic unused_prdata;
  assign unused_prdata = ^prdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_MAGIC;
      addr_q       <= '0;
      cnt_q        <= '0;
      wdata_q      <= '0;
      shift_q      <= '0;
      idx_q        <= '0;
      hold_vld_q   <= 1'b0;
      hold_q       <= '0;
      err_q        <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      req_q        <= '0;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      wdata_q      <= wdata_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      hold_vld_q   <= hold_vld_d;
      hold_q       <= hold_d;
      err_q        <= err_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      req_q        <= req_d;
      core_rst_n_q <= core_rst_n_d;
      busy_q       <= busy_d;
    end
  end

  // Frame parser, holding register and APB sequencing; outputs follow next state
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    hold_vld_d = hold_vld_q;
    hold_d     = hold_q;
    err_d      = err_q | (frame_err && (state_q != S_DONE));
    consume    = 1'b0;
    word       = {hold_q, shift_q};

    case (state_q)
      S_MAGIC: begin
        if (hold_vld_q) begin
          consume = 1'b1;
          if (hold_q == MAGIC) begin
            idx_d   = '0;
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (hold_vld_q) begin
          consume = 1'b1;
          shift_d = word[31:8];
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(ADDR_BYTES - 1)) begin
            addr_d  = word & ADDR_MASK;
            state_d = S_LEN;
          end
        end
      end
      S_LEN: begin
        if (hold_vld_q) begin
          consume = 1'b1;
          shift_d = word[31:8];
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(LEN_BYTES - 1)) begin
            cnt_d   = word;
            state_d = (word == 32'd0) ? S_DONE : S_DATA;
          end
        end
      end
      S_DATA: begin
        if (hold_vld_q) begin
          consume = 1'b1;
          shift_d = word[31:8];
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(WORD_BYTES - 1)) begin
            wdata_d = word;
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (pready) begin
          err_d   = err_d | pslverr;
          addr_d  = addr_q + 32'd4;
          cnt_d   = cnt_q - 32'd1;
          state_d = (cnt_q == 32'd1) ? S_DONE : S_DATA;
        end
      end
      S_DONE: hold_vld_d = 1'b0;
      default: state_d = S_MAGIC;
    endcase

    if (consume) hold_vld_d = 1'b0;

    // A byte that cannot be parked because the previous one is still held is lost
    if (byte_vld && (state_q != S_DONE)) begin
      if (hold_vld_q && !consume) begin
        err_d = 1'b1;
      end else begin
        hold_vld_d = 1'b1;
        hold_d     = byte_data;
      end
    end

    psel_d       = (state_d == S_SETUP) || (state_d == S_ACCESS);
    penable_d    = (state_d == S_ACCESS);
    req_d        = '0;
    if (psel_d) begin
      req_d.paddr  = addr_d;
      req_d.pwdata = wdata_d;
      req_d.pwrite = 1'b1;
      req_d.pwstrb = {SW{1'b1}};
    end
    core_rst_n_d = (state_d == S_DONE);
    busy_d       = (state_d != S_MAGIC) && (state_d != S_DONE);
  end

  assign psel       = psel_q;
  assign penable    = penable_q;
  assign paddr      = req_q.paddr;
  assign pwdata     = req_q.pwdata;
  assign pwrite     = req_q.pwrite;
  assign pwstrb     = req_q.pwstrb;
  assign core_rst_n = core_rst_n_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: serial frames in, APB writes checked against a scoreboard.
module tb_uart_loader;

  localparam int unsigned CPB = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx;
  logic        psel, penable, pready, pwrite, pslverr;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  pwstrb;
  logic        core_rst_n, busy, err;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } xfer_t;

  xfer_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    nwrites = 0;
  int    acc_cnt = 0;
  int    stall_next = 0;
  logic  slverr_next = 1'b0;

  always #5 clk = ~clk;

  uart_loader #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .psel      (psel),
    .penable   (penable),
    .pready    (pready),
    .paddr     (paddr),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .pwstrb    (pwstrb),
    .prdata    (prdata),
    .pslverr   (pslverr),
    .core_rst_n(core_rst_n),
    .busy      (busy),
    .err       (err)
  );

  assign prdata  = 32'd0;
  assign pready  = (acc_cnt >= stall_next);
  assign pslverr = pready && slverr_next && psel && penable;

  always @(posedge clk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // APB slave side: compare each completed write against the scoreboard
  always @(negedge clk) begin
    xfer_t e;
    if (rst_n && psel && penable) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_qsize", 32'(exp_q.size()), 32'd1);
      end else if (pready) begin
        e = exp_q.pop_front();
        chk("paddr", paddr, e.a);
        chk("pwdata", pwdata, e.d);
        chk("pwrite", 32'(pwrite), 32'd1);
        chk("pwstrb", 32'(pwstrb), 32'hF);
        nwrites++;
      end else begin
        chk("stall_paddr", paddr, exp_q[0].a);
        chk("stall_pwdata", pwdata, exp_q[0].d);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk) rx = 1'b0;
    repeat (CPB - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) rx = b[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk) rx = stop;
    repeat (CPB - 1) @(negedge clk);
    @(negedge clk) rx = 1'b1;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic send_hdr(input logic [31:0] a, input logic [31:0] n);
    send_byte(8'hA5, 1'b1);
    send_word(a);
    send_word(n);
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_writes(input int target, input int bound);
    for (int i = 0; i < bound && nwrites < target; i++) @(negedge clk);
    chk("write_count", 32'(nwrites), 32'(target));
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && core_rst_n !== 1'b1; i++) @(negedge clk);
    chk("core_rst_n_done", 32'(core_rst_n), 32'd1);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    xfer_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_pwstrb", 32'(pwstrb), 32'd0);
    chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_core_rst_n", 32'(core_rst_n), 32'd0);

    // Two-word image
    base = nwrites;
    send_byte(8'hA5, 1'b1);
    chk("t1_busy", 32'(busy), 32'd1);
    send_word(32'h0000_0100);
    send_word(32'd2);
    push(32'h0000_0100, 32'h4433_2211);
    push(32'h0000_0104, 32'hDDCC_BBAA);
    send_word(32'h4433_2211);
    send_word(32'hDDCC_BBAA);
    wait_done(200);
    chk("t1_writes", 32'(nwrites - base), 32'd2);
    chk("t1_err", 32'(err), 32'd0);
    chk("t1_busy_end", 32'(busy), 32'd0);

    // Junk before MAGIC, zero-length image
    do_reset();
    base = nwrites;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    chk("t2_busy_idle", 32'(busy), 32'd0);
    send_byte(8'hA5, 1'b1);
    chk("t2_busy", 32'(busy), 32'd1);
    send_word(32'h0000_0010);
    send_word(32'd0);
    chk("t2_core_rst_n", 32'(core_rst_n), 32'd1);
    chk("t2_busy_end", 32'(busy), 32'd0);
    chk("t2_writes", 32'(nwrites - base), 32'd0);

    // Long wait state and slave error on the first word
    do_reset();
    base = nwrites;
    stall_next  = 50;
    slverr_next = 1'b1;
    send_hdr(32'h0000_0200, 32'd2);
    push(32'h0000_0200, 32'h1234_5678);
    push(32'h0000_0204, 32'h9ABC_DEF0);
    send_word(32'h1234_5678);
    wait_writes(base + 1, 100);
    stall_next  = 0;
    slverr_next = 1'b0;
    chk("t3_err_after_w1", 32'(err), 32'd1);
    send_word(32'h9ABC_DEF0);
    wait_done(200);
    chk("t3_writes", 32'(nwrites - base), 32'd2);
    chk("t3_err", 32'(err), 32'd1);

    // Framing error drops one address byte and shifts the parse
    do_reset();
    base = nwrites;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_word(32'd1);
    send_word(32'h1122_3344);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_no_write", 32'(nwrites - base), 32'd0);
    chk("t4_busy", 32'(busy), 32'd1);
    push(32'h0100_0000, 32'hEE11_2233);
    send_byte(8'hEE, 1'b1);
    wait_writes(base + 1, 100);

    // Reset in the middle of an access phase
    do_reset();
    exp_q.delete();
    stall_next = 200;
    send_hdr(32'h0000_0300, 32'd1);
    push(32'h0000_0300, 32'h5555_AAAA);
    send_word(32'h5555_AAAA);
    for (int i = 0; i < 100 && !(psel && penable); i++) @(negedge clk);
    chk("t5_in_access", 32'(psel && penable), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_psel_async", 32'(psel), 32'd0);
    chk("t5_penable_async", 32'(penable), 32'd0);
    chk("t5_core_rst_n", 32'(core_rst_n), 32'd0);
    exp_q.delete();
    stall_next = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    base = nwrites;
    send_hdr(32'h0000_0400, 32'd1);
    push(32'h0000_0400, 32'h0BAD_F00D);
    send_word(32'h0BAD_F00D);
    wait_done(200);
    chk("t5_writes", 32'(nwrites - base), 32'd1);
    chk("t5_err", 32'(err), 32'd0);

    // Unaligned address at the top of memory: masked, then wraps
    do_reset();
    base = nwrites;
    send_hdr(32'hFFFF_FFFE, 32'd2);
    push(32'hFFFF_FFFC, 32'h0102_0304);
    push(32'h0000_0000, 32'hCAFE_F00D);
    send_word(32'h0102_0304);
    send_word(32'hCAFE_F00D);
    wait_done(200);
    chk("t6_writes", 32'(nwrites - base), 32'd2);
    chk("t6_qempty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
